hub_div_issuer: RTL and testbench
=================================

# hub_div_issuer

Initiator-side sequencer for the HUB divider unit behind its FPnew-style port. It accepts one divide request at a time from an upstream client, drives the unit's operand/valid handshake, and captures the single-cycle finish pulse. It returns result, status and request tag through a registered response port, with a watchdog timeout and an abort path that drive the unit's flush.

## Interface
- `E`, 5, exponent bits
- `M`, 10, mantissa bits; `WIDTH = E+M+1`
- `TAG_W`, 4, request tag width
- `TIMEOUT`, 255, max WAIT cycles before abandon (≥2); counter width `$clog2(TIMEOUT+1)`
- `clk_i` in 1: single clock, rising edge
- `rst_i` in 1: reset, synchronous, active-high
- `req_valid_i` in 1 / `req_ready_o` out 1: upstream request handshake
- `req_x_i` in WIDTH: dividend; `req_d_i` in WIDTH: divisor; `req_tag_i` in TAG_W: tag
- `abort_i` in 1: cancel in-flight operation
- `operands_o` out 3×WIDTH: [0]=x, [1]=d, [2]=0
- `op_o` out fpnew_pkg::operation_e: constant DIV; `op_mod_o` out 1: constant 0
- `in_valid_o` out 1 / `in_ready_i` in 1: issue handshake to unit
- `flush_o` out 1: one-cycle flush pulse to unit
- `result_i` in WIDTH, `status_i` in 5 (NV,DZ,OF,UF,NX), `out_valid_i` in 1: unit completion (single-cycle pulse, not held)
- `out_ready_o` out 1: high in WAIT
- `rsp_valid_o` out 1 / `rsp_ready_i` in 1: response handshake
- `rsp_result_o` out WIDTH, `rsp_status_o` out 5, `rsp_tag_o` out TAG_W, `rsp_timeout_o` out 1

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: `req_ready_o`=1. On `req_valid_i`: register x, d, tag; -> ISSUE.
- ISSUE: `in_valid_o`=1, operands held stable. When `in_ready_i`=1: -> WAIT, clear timeout counter. Otherwise stay in ISSUE; no timeout applies here.
- WAIT: `out_ready_o`=1. On `out_valid_i`: register `result_i`, `status_i`, set timeout flag=0; -> RESP. Otherwise increment counter. When counter==TIMEOUT-1 with no `out_valid_i`: result=0, status=0, timeout flag=1; -> RESP.
- RESP: `rsp_valid_o`=1, response fields stable. When `rsp_ready_i`=1: -> IDLE.
- `flush_o` pulses one cycle on entering RESP with timeout flag=1, and on abort.
- abort_i in ISSUE or WAIT: `flush_o`=1 next cycle, -> IDLE, no response. abort_i in IDLE or RESP: ignored.
- `out_valid_i` outside WAIT is ignored and never produces a response.
- `operands_o[1:0]` keep last captured values until the next capture. `result_i` is never modified.

## Timing
- Reset (sampled `rst_i`=1): state IDLE, counter 0. All registered outputs are 0 (`operands_o`, `rsp_*`, `flush_o`). `in_valid_o`=0, `out_ready_o`=0. `req_ready_o`=1 from the first cycle after reset. Reset mid-operation drops the operation silently with no flush.
- All outputs are functions of registered state only; no combinational path from any input to any output.
- Request accepted at edge k -> `in_valid_o`=1 in cycle k+1. If `in_ready_i`=1 in k+1, WAIT begins k+2.
- `out_valid_i` at cycle j in WAIT -> `rsp_valid_o`=1 from j+1.
- Timeout: WAIT entered at cycle w with no completion -> RESP with `rsp_timeout_o`=1 at w+TIMEOUT. `flush_o` is high in that same cycle only.
- `out_valid_i` coinciding with the final timeout cycle: completion wins, timeout flag=0, no flush.
- `abort_i` coinciding with `in_ready_i` (ISSUE) or `out_valid_i` (WAIT): abort wins.
- Throughput: at most one operation in flight. Minimum 4 cycles request-to-request (IDLE, ISSUE, WAIT, RESP).

## Test plan
- Basic: x=16'h3C00, d=16'h4000, tag=3; model asserts `in_ready_i`=1 and pulses `out_valid_i` 12 cycles after issue with result 16'h3800 -> one response: result 16'h3800, tag 3, `rsp_timeout_o`=0; `operands_o[0..1]` stable throughout ISSUE.
- Backpressure: `in_ready_i`=0 for 5 cycles then 1; `rsp_ready_i`=0 for 4 cycles -> `in_valid_o` held 6 cycles; response fields stable all 5 RESP cycles; `req_ready_o`=0 until RESP handshake.
- Timeout: TIMEOUT=8, model never finishes -> `rsp_valid_o` with result 0, `rsp_timeout_o`=1 exactly 8 cycles after WAIT entry; `flush_o` high exactly one cycle.
- Race: `out_valid_i` on cycle TIMEOUT-1 of WAIT -> normal response, `flush_o` stays 0.
- Abort: `abort_i` 3 cycles into WAIT, then a late `out_valid_i` -> `flush_o` one-cycle pulse, no response, back to IDLE; next request (tag 7) completes normally with tag 7.
- Reset: `rst_i` asserted in WAIT -> next cycle all outputs 0, `req_ready_o`=1; a subsequent stray `out_valid_i` produces no response.

Source files
------------

// File: rtl/hub_div_issuer.sv
// hub_div_issuer: initiator-side sequencer for the HUB divider unit.
// Takes one divide request at a time, issues it on the unit's operand/valid
// handshake, captures the single-cycle finish pulse and returns result,
// status and tag on a registered response port. A watchdog and an abort
// input both abandon the operation and pulse the unit's flush.

package fpnew_pkg;
  // Operation encoding of the FPnew-style unit port; this block only drives DIV.
  typedef enum logic [3:0] {
    FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
    CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
  } operation_e;
endpackage

module hub_div_issuer #(
  parameter int unsigned E       = 5,
  parameter int unsigned M       = 10,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned TIMEOUT = 255,
  localparam int unsigned WIDTH  = E + M + 1,
  localparam int unsigned CW     = $clog2(TIMEOUT + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  // upstream request
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [WIDTH-1:0]           req_x_i,
  input  logic [WIDTH-1:0]           req_d_i,
  input  logic [TAG_W-1:0]           req_tag_i,
  input  logic                       abort_i,
  // divider unit
  output logic [2:0][WIDTH-1:0]      operands_o,
  output fpnew_pkg::operation_e      op_o,
  output logic                       op_mod_o,
  output logic                       in_valid_o,
  input  logic                       in_ready_i,
  output logic                       flush_o,
  input  logic [WIDTH-1:0]           result_i,
  input  logic [4:0]                 status_i,
  input  logic                       out_valid_i,
  output logic                       out_ready_o,
  // response
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [WIDTH-1:0]           rsp_result_o,
  output logic [4:0]                 rsp_status_o,
  output logic [TAG_W-1:0]           rsp_tag_o,
  output logic                       rsp_timeout_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   x_q, x_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [4:0]         status_q, status_d;
  logic               timeout_q, timeout_d;
  logic               flush_q, flush_d;

  // Next-state and next-register logic for the request/issue/wait/response sequence.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    state_d   = state_q;
    x_d       = x_q;
    d_d       = d_q;
    tag_d     = tag_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    status_d  = status_q;
    timeout_d = timeout_q;
    flush_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          x_d     = req_x_i;
          d_d     = req_d_i;
          tag_d   = req_tag_i;
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        // Abort beats a coincident issue acceptance.
        if (abort_i) begin
          flush_d = 1'b1;
          state_d = IDLE;
        end else if (in_ready_i) begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end

      WAIT: begin
        // Priority: abort, then completion (even on the last watchdog cycle), then timeout.
        if (abort_i) begin
          flush_d = 1'b1;
          state_d = IDLE;
        end else if (out_valid_i) begin
          result_d  = result_i;
          status_d  = status_i;
          timeout_d = 1'b0;
          state_d   = RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          result_d  = '0;
          status_d  = '0;
          timeout_d = 1'b1;
          flush_d   = 1'b1;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: datapath registers are reset too because they drive outputs that must read 0 after reset.
      state_q   <= IDLE;
      x_q       <= '0;
      d_q       <= '0;
      tag_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      status_q  <= '0;
      timeout_q <= 1'b0;
      flush_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q   <= state_d;
      x_q       <= x_d;
      d_q       <= d_d;
      tag_q     <= tag_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      status_q  <= status_d;
      timeout_q <= timeout_d;
      flush_q   <= flush_d;
    end
  end

  // Every output decodes registered state; nothing passes combinationally from an input.
  assign req_ready_o   = (state_q == IDLE);
  assign in_valid_o    = (state_q == ISSUE);
  assign out_ready_o   = (state_q == WAIT);
  assign rsp_valid_o   = (state_q == RESP);
  assign flush_o       = flush_q;

  assign operands_o[0] = x_q;
  assign operands_o[1] = d_q;
  assign operands_o[2] = '0;
  assign op_o          = fpnew_pkg::DIV;
  assign op_mod_o      = 1'b0;

  assign rsp_result_o  = result_q;
  assign rsp_status_o  = status_q;
  assign rsp_tag_o     = tag_q;
  assign rsp_timeout_o = timeout_q;

endmodule

// File: tb/tb_hub_div_issuer.sv
// Testbench for hub_div_issuer: two instances (default watchdog on u0, an
// 8-cycle watchdog on u1), directed stimulus, and a scoreboard monitor that
// pops expected responses whenever a response handshake completes.

module tb_hub_div_issuer;

  typedef struct packed {
    logic [15:0] result;
    logic [4:0]  status;
    logic [3:0]  tag;
    logic        timeout;
  } rsp_t;

  logic clk;

  logic        rst[2], req_valid[2], abort[2], in_ready[2], out_valid[2], rsp_ready[2];
  logic [15:0] req_x[2], req_d[2], result[2];
  logic [3:0]  req_tag[2];
  logic [4:0]  status[2];

  logic        req_ready[2], in_valid[2], flush[2], out_ready[2], rsp_valid[2];
  logic        op_mod[2], rsp_timeout[2];
  logic [2:0][15:0] operands[2];
  fpnew_pkg::operation_e op[2];
  logic [15:0] rsp_result[2];
  logic [4:0]  rsp_status[2];
  logic [3:0]  rsp_tag[2];

  int n_cmp  = 0;
  int n_fail = 0;

  rsp_t exp0[$];
  rsp_t exp1[$];
  rsp_t mon_e;
  int   mon_sz;

  hub_div_issuer u0 (
    .clk_i(clk), .rst_i(rst[0]),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
    .req_x_i(req_x[0]), .req_d_i(req_d[0]), .req_tag_i(req_tag[0]),
    .abort_i(abort[0]),
    .operands_o(operands[0]), .op_o(op[0]), .op_mod_o(op_mod[0]),
    .in_valid_o(in_valid[0]), .in_ready_i(in_ready[0]), .flush_o(flush[0]),
    .result_i(result[0]), .status_i(status[0]), .out_valid_i(out_valid[0]),
    .out_ready_o(out_ready[0]),
    .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
    .rsp_result_o(rsp_result[0]), .rsp_status_o(rsp_status[0]),
    .rsp_tag_o(rsp_tag[0]), .rsp_timeout_o(rsp_timeout[0])
  );

  hub_div_issuer #(.TIMEOUT(8)) u1 (
    .clk_i(clk), .rst_i(rst[1]),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
    .req_x_i(req_x[1]), .req_d_i(req_d[1]), .req_tag_i(req_tag[1]),
    .abort_i(abort[1]),
    .operands_o(operands[1]), .op_o(op[1]), .op_mod_o(op_mod[1]),
    .in_valid_o(in_valid[1]), .in_ready_i(in_ready[1]), .flush_o(flush[1]),
    .result_i(result[1]), .status_i(status[1]), .out_valid_i(out_valid[1]),
    .out_ready_o(out_ready[1]),
    .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
    .rsp_result_o(rsp_result[1]), .rsp_status_o(rsp_status[1]),
    .rsp_tag_o(rsp_tag[1]), .rsp_timeout_o(rsp_timeout[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so a stuck run still terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int u, input rsp_t e);
    if (u == 0) exp0.push_back(e);
    else        exp1.push_back(e);
  endtask

  // Present a request for one cycle; returns in the first ISSUE cycle.
  task automatic send(input int u, input logic [15:0] x, input logic [15:0] d, input logic [3:0] tag);
    req_valid[u] = 1'b1;
    req_x[u]     = x;
    req_d[u]     = d;
    req_tag[u]   = tag;
    tick();
    req_valid[u] = 1'b0;
  endtask

  // Unit model finish pulse; the expected response is queued before the DUT can show it.
  task automatic complete(input int u, input logic [15:0] r, input logic [4:0] s, input logic [3:0] tag);
    rsp_t e;
    e = '{result: r, status: s, tag: tag, timeout: 1'b0};
    push(u, e);
    out_valid[u] = 1'b1;
    result[u]    = r;
    status[u]    = s;
    tick();
    out_valid[u] = 1'b0;
  endtask

  // Scoreboard monitor: any visible response must be expected; a completed handshake pops and compares.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (rsp_valid[u] === 1'b1) begin
        mon_sz = (u == 0) ? exp0.size() : exp1.size();
        if (mon_sz == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL rsp%0d_unexpected: got response tag %0h, required no response", u, rsp_tag[u]);
        end else if (rsp_ready[u] === 1'b1) begin
          if (u == 0) mon_e = exp0.pop_front();
          else        mon_e = exp1.pop_front();
          check($sformatf("rsp%0d_result", u),  32'(rsp_result[u]),  32'(mon_e.result));
          check($sformatf("rsp%0d_status", u),  32'(rsp_status[u]),  32'(mon_e.status));
          check($sformatf("rsp%0d_tag", u),     32'(rsp_tag[u]),     32'(mon_e.tag));
          check($sformatf("rsp%0d_timeout", u), 32'(rsp_timeout[u]), 32'(mon_e.timeout));
        end
      end
    end
  end

  initial begin
    rsp_t e;
    for (int u = 0; u < 2; u++) begin
      rst[u] = 1'b1; req_valid[u] = 1'b0; abort[u] = 1'b0; in_ready[u] = 1'b1;
      out_valid[u] = 1'b0; rsp_ready[u] = 1'b1;
      req_x[u] = '0; req_d[u] = '0; req_tag[u] = '0; result[u] = '0; status[u] = '0;
    end

    // ---------------- reset state ----------------
    tick();
    tick();
    check("rst_req_ready", 32'(req_ready[0]), 32'd1);
    check("rst_in_valid",  32'(in_valid[0]),  32'd0);
    check("rst_out_ready", 32'(out_ready[0]), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    check("rst_flush",     32'(flush[0]),     32'd0);
    check("rst_operands",  32'(operands[0]),  32'd0);
    check("rst_rsp_fields", {rsp_result[0], rsp_status[0], rsp_tag[0], rsp_timeout[0]}, 32'd0);
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // ---------------- basic: 1.0 / 2.0 = 0.5 ----------------
    send(0, 16'h3C00, 16'h4000, 4'd3);
    check("basic_in_valid", 32'(in_valid[0]),    32'd1);
    check("basic_req_ready", 32'(req_ready[0]),  32'd0);
    check("basic_op_x",     32'(operands[0][0]), 32'h3C00);
    check("basic_op_d",     32'(operands[0][1]), 32'h4000);
    check("basic_op_2",     32'(operands[0][2]), 32'h0);
    check("basic_op",       32'(op[0]),          32'(fpnew_pkg::DIV));
    check("basic_op_mod",   32'(op_mod[0]),      32'd0);
    tick();
    check("basic_out_ready", 32'(out_ready[0]), 32'd1);
    check("basic_in_valid_off", 32'(in_valid[0]), 32'd0);
    repeat (11) tick();
    complete(0, 16'h3800, 5'b00000, 4'd3);
    check("basic_rsp_valid", 32'(rsp_valid[0]), 32'd1);
    check("basic_resp_req_ready", 32'(req_ready[0]), 32'd0);
    tick();
    check("basic_back_idle", 32'(req_ready[0]), 32'd1);

    // ---------------- backpressure: 5.0 / 1.0 ----------------
    in_ready[0] = 1'b0;
    send(0, 16'h4500, 16'h3C00, 4'd9);
    for (int i = 1; i <= 6; i++) begin
      check($sformatf("bp_in_valid_c%0d", i), 32'(in_valid[0]), 32'd1);
      check($sformatf("bp_ops_c%0d", i), {operands[0][1], operands[0][0]}, 32'h3C00_4500);
      check($sformatf("bp_req_ready_c%0d", i), 32'(req_ready[0]), 32'd0);
      in_ready[0] = (i == 6);
      tick();
    end
    check("bp_in_valid_released", 32'(in_valid[0]), 32'd0);
    repeat (2) tick();
    rsp_ready[0] = 1'b0;
    complete(0, 16'h4500, 5'b00001, 4'd9);
    for (int i = 1; i <= 5; i++) begin
      check($sformatf("bp_rsp_valid_c%0d", i), 32'(rsp_valid[0]), 32'd1);
      check($sformatf("bp_rsp_fields_c%0d", i),
            {rsp_result[0], rsp_status[0], rsp_tag[0], rsp_timeout[0]},
            {16'h4500, 5'b00001, 4'd9, 1'b0});
      check($sformatf("bp_rsp_req_ready_c%0d", i), 32'(req_ready[0]), 32'd0);
      rsp_ready[0] = (i == 5);
      tick();
    end
    check("bp_done_req_ready", 32'(req_ready[0]), 32'd1);
    check("bp_done_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    in_ready[0]  = 1'b1;
    rsp_ready[0] = 1'b1;

    // ---------------- race on u1 (TIMEOUT=8): completion on final WAIT cycle ----------------
    send(1, 16'h4400, 16'h4000, 4'd6);
    tick();                                // WAIT entry, cycle w
    for (int i = 0; i < 7; i++) begin
      check($sformatf("race_flush_w%0d", i), 32'(flush[1]), 32'd0);
      tick();
    end
    complete(1, 16'h4000, 5'b00000, 4'd6); // pulse on w+7, counter at TIMEOUT-1
    check("race_rsp_valid", 32'(rsp_valid[1]), 32'd1);
    check("race_flush",     32'(flush[1]),     32'd0);
    check("race_timeout",   32'(rsp_timeout[1]), 32'd0);
    tick();
    check("race_flush_after", 32'(flush[1]), 32'd0);

    // ---------------- timeout on u1: unit never finishes ----------------
    rsp_ready[1] = 1'b0;
    send(1, 16'h3C00, 16'h0000, 4'd5);
    tick();                                // WAIT entry, cycle w
    e = '{result: 16'h0, status: 5'h0, tag: 4'd5, timeout: 1'b1};
    push(1, e);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("to_rsp_valid_w%0d", i), 32'(rsp_valid[1]), 32'd0);
      check($sformatf("to_flush_w%0d", i),     32'(flush[1]),     32'd0);
      tick();
    end
    check("to_rsp_valid", 32'(rsp_valid[1]),   32'd1);
    check("to_timeout",   32'(rsp_timeout[1]), 32'd1);
    check("to_result",    32'(rsp_result[1]),  32'd0);
    check("to_flush",     32'(flush[1]),       32'd1);
    tick();
    check("to_flush_once", 32'(flush[1]), 32'd0);
    rsp_ready[1] = 1'b1;
    tick();
    check("to_back_idle", 32'(req_ready[1]), 32'd1);

    // ---------------- abort in ISSUE, coinciding with in_ready ----------------
    send(0, 16'h4000, 16'h4000, 4'd1);
    abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    check("abi_flush",     32'(flush[0]),     32'd1);
    check("abi_req_ready", 32'(req_ready[0]), 32'd1);
    check("abi_out_ready", 32'(out_ready[0]), 32'd0);
    tick();
    check("abi_flush_once", 32'(flush[0]), 32'd0);

    // ---------------- abort 3 cycles into WAIT, then a late finish ----------------
    send(0, 16'h4000, 16'h3C00, 4'd2);
    tick();                                // WAIT entry, cycle w
    repeat (3) tick();
    abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    check("abw_flush",     32'(flush[0]),     32'd1);
    check("abw_req_ready", 32'(req_ready[0]), 32'd1);
    check("abw_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    out_valid[0] = 1'b1;
    result[0]    = 16'h1234;
    status[0]    = 5'b10000;
    tick();
    out_valid[0] = 1'b0;
    check("abw_flush_once", 32'(flush[0]), 32'd0);
    repeat (3) begin
      check("abw_no_rsp", 32'(rsp_valid[0]), 32'd0);
      tick();
    end
    // 3.0 / 2.0 = 1.5
    send(0, 16'h4200, 16'h4000, 4'd7);
    check("abw_next_in_valid", 32'(in_valid[0]), 32'd1);
    tick();
    tick();
    complete(0, 16'h3E00, 5'b00000, 4'd7);
    tick();

    // ---------------- reset in WAIT ----------------
    send(0, 16'h3C00, 16'h4000, 4'd4);
    tick();
    tick();
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    check("mrst_req_ready", 32'(req_ready[0]), 32'd1);
    check("mrst_in_valid",  32'(in_valid[0]),  32'd0);
    check("mrst_out_ready", 32'(out_ready[0]), 32'd0);
    check("mrst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    check("mrst_flush",     32'(flush[0]),     32'd0);
    check("mrst_operands",  32'(operands[0]),  32'd0);
    check("mrst_rsp_fields", {rsp_result[0], rsp_status[0], rsp_tag[0], rsp_timeout[0]}, 32'd0);
    out_valid[0] = 1'b1;
    result[0]    = 16'h5555;
    tick();
    out_valid[0] = 1'b0;
    repeat (3) begin
      check("mrst_no_rsp", 32'(rsp_valid[0]), 32'd0);
      check("mrst_no_flush", 32'(flush[0]), 32'd0);
      tick();
    end

    // ---------------- drain ----------------
    repeat (2) tick();
    check("q0_drained", 32'(exp0.size()), 32'd0);
    check("q1_drained", 32'(exp1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
